uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame.
REQ-002 Parameter STOP_TICKS, default 16: stop-bit length in tick_in pulses (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 Parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 clock  input  1  system clock; all registers update on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 tick_in  input  1  one-clock-wide pulse at 16x the baud rate, from the baud-rate generator.
REQ-008 tx_start  input  1  request to send dato_in; sampled on a clock edge.
REQ-009 dato_in  input  DATA_BITS  byte to transmit; captured when tx_start is accepted.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 tx_done_tick  output  1  one-clock pulse at frame completion.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with a 4-bit tick counter s, a data-bit counter n and a shift register b.
REQ-014 In IDLE, tx SHALL be 1; tx_start=1 SHALL load b<=dato_in, clear s and n, and enter START, with tx=0 from the next clock.
REQ-015 Bit timing in START, DATA and PARITY SHALL follow one rule: on each tick_in, if s==15 then s<=0 and advance, else s<=s+1.
- Each bit therefore spans 16 tick_in pulses.
- Clocks without tick_in SHALL leave s unchanged.
REQ-016 The START state SHALL drive tx=0; on its 16th tick it SHALL enter DATA.
REQ-017 The DATA state SHALL drive tx=b[0], sending LSB first; at each bit end it SHALL shift b right.
- If n==DATA_BITS-1, it SHALL go to PARITY when PARITY_EN=1, else to STOP.
- Otherwise it SHALL increment n.
REQ-018 The PARITY state SHALL drive tx as follows: even parity sends the XOR of the captured byte; odd parity sends its inverse. After 16 ticks it SHALL enter STOP.
REQ-019 The STOP state SHALL drive tx=1 for STOP_TICKS ticks; s SHALL be wide enough for STOP_TICKS-1.
- On the final tick, tx_done_tick SHALL be 1 for exactly that clock and the state SHALL return to IDLE.
REQ-020 The parity value SHALL be computed from the byte captured at acceptance, not from live dato_in.
REQ-021 tx_start while busy=1 SHALL be ignored; no queuing. Changes on dato_in during a frame SHALL NOT affect the frame.
REQ-022 tx_start asserted in the same clock as the IDLE return SHALL be ignored; it is accepted from the following clock.
REQ-023 Back-to-back frames SHALL add no extra idle bit beyond the single IDLE clock.
REQ-024 busy SHALL be combinationally equal to (state != IDLE).
REQ-025 tx_done_tick SHALL be 0 in every clock other than the STOP-exit clock.

Reset
REQ-026 When reset=1, regardless of clock, the block SHALL immediately set: state=IDLE, tx=1, tx_done_tick=0, busy=0, s=0, n=0, b=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no tx_done_tick; tx SHALL return high at once.
REQ-028 After reset deassertion, the first tx_start SHALL start a complete, correct frame.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Default parameters, tx_start pulse with dato_in=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 tick_in long; one tx_done_tick; busy high throughout.
- PARITY_EN=1, PARITY_ODD=0, dato_in=8'h07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 11 bits.
- tx_start re-pulsed with dato_in=8'hFF during the DATA state of an 8'h00 frame -> the frame still carries 8'h00; no second frame starts.
- tx_start held high continuously with 8'h55 -> consecutive frames separated by exactly one IDLE clock; one tx_done_tick per frame.
- reset asserted at the 3rd data bit -> tx=1 and busy=0 immediately, no tx_done_tick; a subsequent 8'h3C frame is correct.
- STOP_TICKS=32 -> stop bit lasts 32 tick_in; tx_done_tick on the 32nd stop tick.

Source files
------------

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle for the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick_in;
  logic                 tx_start;
  logic [DATA_BITS-1:0] dato_in;
  logic                 tx;
  logic                 tx_done_tick;
  logic                 busy;

  modport master (
    output tick_in, tx_start, dato_in,
    input  tx, tx_done_tick, busy
  );

  modport slave (
    input  tick_in, tx_start, dato_in,
    output tx, tx_done_tick, busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s),
// timed by a 16x-baud tick. Serial line is registered and idles high.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic clock,
  input  logic reset,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Tick counter must hold both 15 (bit cells) and STOP_TICKS-1 (stop cell).
  localparam int S_W = (STOP_TICKS > 16) ? $clog2(STOP_TICKS) : 4;
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_BITS - 1);
  localparam logic           ODD         = (PARITY_ODD != 0);
  localparam logic           PAR_ON      = (PARITY_EN != 0);

  state_t               state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_c;

  // State, counters, shift register and line register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state, bit timing and next line value.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    done_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          b_d     = bus.dato_in;
          // Parity is frozen at acceptance so later dato_in changes cannot leak in.
          par_d   = (^bus.dato_in) ^ ODD;
          s_d     = '0;
          n_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (bus.tick_in) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (bus.tick_in) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              state_d = PAR_ON ? PARITY : STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      PARITY: begin
        if (bus.tick_in) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (bus.tick_in) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            state_d = IDLE;
            done_c  = 1'b1;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value is decoded from the next state so tx is a clean flop output.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx           = tx_q;
  assign bus.tx_done_tick = done_c;
  assign bus.busy         = (state_q != IDLE);

endmodule
